// File: rtl/count_seq_ctrl_pkg.sv
// count_seq_ctrl_pkg: state encoding and prescaler width helpers for count_seq_ctrl
package count_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int presc_w(input int p);
    return clog2(p + 1) > 1 ? clog2(p + 1) : 1;
  endfunction
endpackage

// File: rtl/univ_bin_counter.sv
// univ_bin_counter: N-bit up/down counter with sync clear, parallel load and enable
module univ_bin_counter #(
  parameter int N = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (syn_clr) q <= '0;
    else if (load) q <= d;
    else if (en) q <= up ? q + 1'b1 : q - 1'b1;
endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: runs load/step/terminate count jobs on a univ_bin_counter with prescaling, pause and abort
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int N     = 11,
  parameter int PRESC = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] start_val,
  input  logic [N-1:0] end_val,
  input  logic         dir_up,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         aborted
);
  localparam int PW = presc_w(PRESC);
  localparam logic [PW-1:0] PMAX = PW'(PRESC);
  state_t state;
  logic [PW-1:0] presc_cnt;
  logic [N-1:0] end_lat, nxt;
  logic dir_lat, step, load, en;
  assign step = state == RUN && presc_cnt == PMAX && !pause;
  assign load = state == IDLE && start && !abort;
  assign en   = step && !abort;
  assign nxt  = dir_lat ? q + 1'b1 : q - 1'b1;
  assign busy = state != IDLE;
  univ_bin_counter #(.N(N)) u_cnt (
    .clk(clk), .reset(reset), .syn_clr(abort), .load(load), .en(en),
    .up(dir_lat), .d(start_val), .q(q)
  );
  // terminal detection looks at the value the pending step will produce, so done lines up with q==end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      presc_cnt <= '0;
      end_lat   <= '0;
      dir_lat   <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        aborted <= state != IDLE;
      end else
        case (state)
          IDLE: if (start) begin
            end_lat   <= end_val;
            dir_lat   <= dir_up;
            presc_cnt <= '0;
            state     <= start_val == end_val ? DONE : RUN;
            done      <= start_val == end_val;
          end
          RUN: if (!pause) begin
            presc_cnt <= presc_cnt == PMAX ? '0 : presc_cnt + 1'b1;
            if (step && nxt == end_lat) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: vector table, directed corner sequences and randomized model check for count_seq_ctrl
module tb_count_seq_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, dir_up = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [10:0] start_val = '0, end_val = '0;
  logic [10:0] q0, q2;
  logic busy0, done0, aborted0, busy2, done2, aborted2;
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  count_seq_ctrl #(.N(11), .PRESC(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .start_val(start_val), .end_val(end_val),
    .dir_up(dir_up), .pause(pause), .abort(abort), .q(q0), .busy(busy0), .done(done0), .aborted(aborted0)
  );
  count_seq_ctrl #(.N(11), .PRESC(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .start_val(start_val), .end_val(end_val),
    .dir_up(dir_up), .pause(pause), .abort(abort), .q(q2), .busy(busy2), .done(done2), .aborted(aborted2)
  );

  typedef struct {bit st; int sv; int ev; bit du; bit pa; bit ab; int eq; bit eb; bit ed; bit ea;} vec_t;
  vec_t tbl[$];

  // job-level reference: q is start +/- (active RUN cycles / (PRESC+1)), job ends when that reaches the distance
  typedef struct {int mode; int q; int sv; int tot; int a; bit dir; bit done; bit abt;} m_t;

  function automatic m_t mstep(m_t m, int p, bit st, int sv, int ev, bit du, bit pa, bit ab);
    int s;
    m.done = 1'b0;
    m.abt  = 1'b0;
    if (m.mode == 0) begin
      if (ab) m.q = 0;
      else if (st) begin
        m.q = sv; m.sv = sv; m.dir = du; m.a = 0;
        m.tot  = (du ? ev - sv : sv - ev) & 2047;
        m.mode = m.tot == 0 ? 2 : 1;
        m.done = m.tot == 0;
      end
    end else if (ab) begin
      m.q = 0; m.mode = 0; m.abt = 1'b1;
    end else if (m.mode == 2) m.mode = 0;
    else if (!pa) begin
      m.a++;
      s = m.a / (p + 1);
      m.q = (m.dir ? m.sv + s : m.sv - s) & 2047;
      if (s == m.tot) begin m.mode = 2; m.done = 1'b1; end
    end
    return m;
  endfunction

  function void add(bit st, int sv, int ev, bit du, bit pa, bit ab, int eq, bit eb, bit ed, bit ea);
    tbl.push_back('{st, sv, ev, du, pa, ab, eq, eb, ed, ea});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit st, input int sv, input int ev, input bit du, input bit pa, input bit ab);
    start = st; start_val = 11'(sv); end_val = 11'(ev); dir_up = du; pause = pa; abort = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_t m0, m2;
    int sv, ev;
    // reset state
    tick();
    chk("rst_q", q0, 0); chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_abt", aborted0, 0);
    reset = 1'b0;
    tick();

    // 3 -> 6 up, then start in DONE ignored on a 3 -> 4 job
    add(1, 3, 6, 1, 0, 0, 3, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 5, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 6, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 6, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 6, 0, 0, 0);
    add(1, 3, 4, 1, 0, 0, 3, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 4, 1, 1, 0);
    add(1, 50, 60, 1, 0, 0, 4, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    // start_val == end_val: straight to DONE
    add(1, 7, 7, 0, 0, 0, 7, 1, 1, 0); add(0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
    // abort in IDLE clears q, beats start, no pulse
    add(1, 9, 12, 1, 0, 1, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // wrap up and down
    add(1, 2046, 1, 1, 0, 0, 2046, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 2047, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 2046, 0, 0, 0, 1, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2047, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 2046, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2046, 0, 0, 0);
    // pause for 5 cycles in a 0 -> 4 job
    add(1, 0, 4, 1, 0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    // abort at q=5 in a 0 -> 20 job, with an ignored start mid-job
    add(1, 0, 20, 1, 0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 100, 100, 0, 0, 0, 2, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // abort during DONE
    add(1, 5, 5, 1, 0, 0, 5, 1, 1, 0); add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sv, tbl[i].ev, tbl[i].du, tbl[i].pa, tbl[i].ab);
      tick();
      chk($sformatf("vec%0d_q", i), q0, tbl[i].eq);
      chk($sformatf("vec%0d_busy", i), busy0, tbl[i].eb);
      chk($sformatf("vec%0d_done", i), done0, tbl[i].ed);
      chk($sformatf("vec%0d_abt", i), aborted0, tbl[i].ea);
    end

    // PRESC=2: 10 -> 8 down, one step per 3 RUN cycles
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(1, 10, 8, 0, 0, 0); tick();
    chk("p2_load_q", q2, 10); chk("p2_load_busy", busy2, 1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("p2_c%0d_q", i), q2, i < 3 ? 10 : (i < 6 ? 9 : 8));
      chk($sformatf("p2_c%0d_done", i), done2, i == 6);
    end
    tick();
    chk("p2_idle_busy", busy2, 0); chk("p2_idle_q", q2, 8);

    // async reset mid-run at q=12
    drive(1, 0, 20, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) tick();
    chk("ar_pre_q", q0, 12);
    #3 reset = 1'b1;
    #1;
    chk("ar_q", q0, 0); chk("ar_busy", busy0, 0);
    chk("ar_done", done0, 0); chk("ar_abt", aborted0, 0);
    tick();
    reset = 1'b0;
    chk("ar_hold_done", done0, 0);
    drive(1, 3, 4, 1, 0, 0); tick();
    chk("ar_new_q", q0, 3); chk("ar_new_busy", busy0, 1);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("ar_new_end_q", q0, 4); chk("ar_new_done", done0, 1);

    // randomized run against the reference model on both prescaler settings
    reset = 1'b1; tick(); reset = 1'b0;
    m0 = '{default: 0}; m2 = '{default: 0};
    for (int i = 0; i < 3000; i++) begin
      sv = int'($urandom_range(0, 2047));
      ev = (sv + int'($urandom_range(0, 12)) - 6) & 2047;
      drive($urandom_range(0, 2) == 0, sv, ev, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
      @(posedge clk);
      m0 = mstep(m0, 0, start, int'(start_val), int'(end_val), dir_up, pause, abort);
      m2 = mstep(m2, 2, start, int'(start_val), int'(end_val), dir_up, pause, abort);
      #1;
      chk("rnd0_q", q0, m0.q); chk("rnd0_busy", busy0, m0.mode != 0);
      chk("rnd0_done", done0, m0.done); chk("rnd0_abt", aborted0, m0.abt);
      chk("rnd2_q", q2, m2.q); chk("rnd2_busy", busy2, m2.mode != 0);
      chk("rnd2_done", done2, m2.done); chk("rnd2_abt", aborted2, m2.abt);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
